// File: rtl/web1_wake_pkg.sv
// Shared types and constants for the web1 wake-event controller.
package web1_wake_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SLEEP = 2'd1,
      WAKE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   localparam int EVT_LOW_PWR  = 0;
   localparam int EVT_SUPPRESS = 1;
   localparam int EVT_WAKE_NOW = 2;
   localparam int EVT_EPU_EN   = 3;

   function automatic logic edge_hit(input edge_mode_t mode, input logic cur, input logic prev);
      logic hit;
      case (mode)
         EDGE_OFF:  hit = 1'b0;
         EDGE_RISE: hit = cur & ~prev;
         EDGE_FALL: hit = ~cur & prev;
         EDGE_BOTH: hit = cur ^ prev;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/web1_wake_ctrl_edge_det.sv
// Synchronizer plus selectable edge detector for one asynchronous control event.
// Detect output is registered: an input edge shows up SYNC_STAGES+1 clocks later.
module web1_edge_det
   import web1_wake_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_async,
   input  edge_mode_t i_mode,
   output logic       o_det
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_det;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_det  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_sync;
         r_det  <= edge_hit(i_mode, w_sync, r_prev);
      end
   end

   assign o_det = r_det;

endmodule

// File: rtl/web1_wake_ctrl.sv
// Wake-event controller: pin/event synchronization, status set strobes and sleep/wake FSM.
// Optional macro WEB1_WAKE_CAUSE_EN adds wake_cause / wake_cause_vld capture.
module web1_wake_ctrl
   import web1_wake_pkg::*;
#(
   parameter int NUM_WAKE    = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_WAKE-1:0] wake_in,
   input  logic [3:0]          ctl_evt_in,
   input  logic [NUM_WAKE-1:0] enable_q,
   input  logic [NUM_WAKE-1:0] invert_q,
   input  logic [7:0]          edge_q,
   input  logic [3:0]          evt_q,
   output logic [3:0]          evt_d,
   output logic [3:0]          evt_enb,
   output logic                wake_req,
   input  logic                wake_ack,
   output logic                sleeping,
   output logic [NUM_WAKE-1:0] pending
`ifdef WEB1_WAKE_CAUSE_EN
   ,
   output logic [$clog2(NUM_WAKE)-1:0] wake_cause,
   output logic                        wake_cause_vld
`endif
);

   logic [NUM_WAKE-1:0] r_pin_sync [SYNC_STAGES];
   logic [NUM_WAKE-1:0] r_pending;
   logic [NUM_WAKE-1:0] w_pin_masked;
   logic [3:0]          w_det;
   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_epu_off;
   logic                w_pin_wake;
   logic                w_unused_evt_q;

   for (genvar k = 0; k < 4; k++) begin : g_evt
      web1_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge_det (
         .clk     (clk),
         .rst     (rst),
         .i_async (ctl_evt_in[k]),
         .i_mode  (edge_mode_t'(edge_q[2*k +: 2])),
         .o_det   (w_det[k])
      );
   end

   // Status bits 0 and 2 are pure strobes here; their stored value plays no role.
   assign w_unused_evt_q = ^{evt_q[EVT_LOW_PWR], evt_q[EVT_WAKE_NOW]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_pin_sync[s] <= '0;
         end
      end else begin
         r_pin_sync[0] <= wake_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_pin_sync[s] <= r_pin_sync[s-1];
         end
      end
   end

   assign w_pin_masked = (r_pin_sync[SYNC_STAGES-1] ^ invert_q) & enable_q;
   assign w_epu_off    = ~evt_q[EVT_EPU_EN];
   assign w_pin_wake   = (|r_pending) & ~evt_q[EVT_SUPPRESS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else if (w_epu_off || (r_state == WAKE && wake_ack)) begin
         r_pending <= '0;
      end else if (r_state == SLEEP) begin
         r_pending <= r_pending | w_pin_masked;
      end else begin
         r_pending <= r_pending;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Dropping epu_enable forces RUN from any state and outranks every other cause.
   always_comb begin
      w_state_nxt = r_state;
      if (w_epu_off) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            RUN:     w_state_nxt = w_det[EVT_LOW_PWR] ? SLEEP : RUN;
            SLEEP:   w_state_nxt = (w_det[EVT_WAKE_NOW] || w_pin_wake) ? WAKE : SLEEP;
            WAKE:    w_state_nxt = wake_ack ? RUN : WAKE;
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      wake_req = 1'b0;
      sleeping = 1'b0;
      case (r_state)
         SLEEP:   sleeping = 1'b1;
         WAKE:    wake_req = 1'b1;
         default: begin
            wake_req = 1'b0;
            sleeping = 1'b0;
         end
      endcase
   end

   assign evt_enb = w_det;
   assign evt_d   = w_det;
   assign pending = r_pending;

`ifdef WEB1_WAKE_CAUSE_EN
   localparam int CW = $clog2(NUM_WAKE);

   logic [CW-1:0] w_low_idx;
   logic [CW-1:0] r_cause;
   logic          r_cause_vld;

   // Descending scan so the last hit written is the lowest set pending bit.
   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_WAKE - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_low_idx = CW'(i);
         end else begin
            w_low_idx = w_low_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cause     <= '0;
         r_cause_vld <= 1'b0;
      end else if (r_state == SLEEP && w_state_nxt == WAKE) begin
         r_cause     <= w_pin_wake ? w_low_idx : '0;
         r_cause_vld <= w_pin_wake;
      end else begin
         r_cause     <= r_cause;
         r_cause_vld <= r_cause_vld;
      end
   end

   assign wake_cause     = r_cause;
   assign wake_cause_vld = r_cause_vld;
`endif

endmodule
